// File: rtl/common_pseudo_lru_tree_binw.sv
`default_nettype none
// ============================================================================
//  Module   : common_pseudo_lru_tree_binw
//  Purpose  : Multi-set binary-tree pseudo-LRU victim selector. Each set holds
//             P_COUNT-1 tree bits in heap order (node 1 = root, children of
//             node i are 2i and 2i+1, way 0 is the leftmost leaf). A node bit
//             of 0 points the victim into the left subtree, 1 into the right.
//             Touches steer every node on the touched way's path away from it.
//             Queries return a registered victim one cycle later. The victim
//             is the lowest invalid way when any way is invalid, otherwise the
//             tree victim.
//  Ports    : clk      - clock, all state updates on the rising edge
//             reset    - synchronous active-high reset
//             wset     - set index of a touch
//             waddr    - binary way index of a touch
//             wen      - touch strobe
//             qset     - set index of a victim query
//             qinvalid - per-way invalid mask for the query set
//             qen      - query strobe
//             qvalid   - victim result valid (one cycle after qen)
//             qaddr    - binary victim way
//             qfrominv - victim was taken from qinvalid, not from the tree
//  Revision : 1.0 - initial release
// ============================================================================
module common_pseudo_lru_tree_binw #(
   parameter int SUBJECT_COUNT_LOG2 = 2,
   parameter int SET_COUNT_LOG2     = 2
) (
   input  logic                                              clk,
   input  logic                                              reset,
   input  logic [((SET_COUNT_LOG2 > 0) ? SET_COUNT_LOG2 : 1)-1:0] wset,
   input  logic [SUBJECT_COUNT_LOG2-1:0]                     waddr,
   input  logic                                              wen,
   input  logic [((SET_COUNT_LOG2 > 0) ? SET_COUNT_LOG2 : 1)-1:0] qset,
   input  logic [(1 << SUBJECT_COUNT_LOG2)-1:0]              qinvalid,
   input  logic                                              qen,
   output logic                                              qvalid,
   output logic [SUBJECT_COUNT_LOG2-1:0]                     qaddr,
   output logic                                              qfrominv
);

   localparam int c_L       = SUBJECT_COUNT_LOG2;
   localparam int c_P_COUNT = 1 << SUBJECT_COUNT_LOG2;
   localparam int c_S_COUNT = 1 << SET_COUNT_LOG2;
   localparam int c_SET_W   = (SET_COUNT_LOG2 > 0) ? SET_COUNT_LOG2 : 1;
   localparam logic [SUBJECT_COUNT_LOG2-1:0] c_ROOT = 1;

   // Tree bits per set, indexed directly by heap node number (1..P_COUNT-1).
   logic [c_P_COUNT-1:1] r_tree [c_S_COUNT];

   logic [c_SET_W-1:0]   w_wset_idx;
   logic [c_SET_W-1:0]   w_qset_idx;
   logic [c_P_COUNT-1:1] w_qtree;
   logic [c_P_COUNT-1:1] w_path_mask;
   logic [c_P_COUNT-1:1] w_path_val;
   logic [c_L-1:0]       w_tree_victim;
   logic [c_L-1:0]       w_inv_idx;
   logic                 w_any_inv;

   logic                 r_qvalid;
   logic [c_L-1:0]       r_qaddr;
   logic                 r_qfrominv;

   // With a single set the set indices carry no information.
   generate
      if (SET_COUNT_LOG2 == 0) begin : g_single_set
         logic w_unused_sets;
         assign w_wset_idx    = '0;
         assign w_qset_idx    = '0;
         assign w_unused_sets = ^{wset, qset};
      end else begin : g_multi_set
         assign w_wset_idx = wset;
         assign w_qset_idx = qset;
      end
   endgenerate

   assign w_qtree = r_tree[w_qset_idx];

   // Touch path: node (2^l + p) at level l lies on the path of waddr when the
   // top l bits of waddr equal p. Its new value points to the sibling subtree,
   // i.e. the inverse of the branch bit waddr takes at that level.
   generate
      for (genvar l = 0; l < c_L; l++) begin : g_path_lvl
         for (genvar p = 0; p < (1 << l); p++) begin : g_path_node
            localparam int c_NODE = (1 << l) + p;
            assign w_path_mask[c_NODE] = ((waddr >> (c_L - l)) == c_L'(p));
            assign w_path_val[c_NODE]  = ~waddr[c_L-1-l];
         end
      end
   endgenerate

   // Tree walk: each level reads the bit of the current node, which is the
   // next victim address bit (MSB first), and descends to child 2n + bit.
   generate
      for (genvar l = 0; l < c_L; l++) begin : g_walk
         logic [c_L-1:0] node;
         logic           bit_v;
         if (l == 0) begin : g_root
            assign node = c_ROOT;
         end else begin : g_child
            assign node = {g_walk[l-1].node[c_L-2:0], g_walk[l-1].bit_v};
         end
         assign bit_v               = w_qtree[node];
         assign w_tree_victim[c_L-1-l] = bit_v;
      end
   endgenerate

   // Lowest set bit of the invalid mask.
   always_comb begin
      w_inv_idx = '0;
      for (int i = c_P_COUNT - 1; i >= 0; i--) begin
         if (qinvalid[i]) begin
            w_inv_idx = c_L'(i);
         end
      end
   end

   assign w_any_inv = |qinvalid;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < c_S_COUNT; s++) begin
            r_tree[s] <= '0;
         end
      end else if (wen) begin
         r_tree[w_wset_idx] <= (r_tree[w_wset_idx] & ~w_path_mask) |
                               (w_path_val & w_path_mask);
      end
   end

   // The query reads the tree before this edge's touch lands, so a same-edge
   // touch is not reflected in the result.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_qvalid   <= 1'b0;
         r_qaddr    <= '0;
         r_qfrominv <= 1'b0;
      end else begin
         r_qvalid <= qen;
         if (qen) begin
            r_qaddr    <= w_any_inv ? w_inv_idx : w_tree_victim;
            r_qfrominv <= w_any_inv;
         end
      end
   end

   assign qvalid   = r_qvalid;
   assign qaddr    = r_qaddr;
   assign qfrominv = r_qfrominv;

endmodule
`default_nettype wire

// File: tb/tb_common_pseudo_lru_tree_binw.sv
`default_nettype none
// ============================================================================
//  Module   : tb_common_pseudo_lru_tree_binw
//  Purpose  : Directed self-checking bench. dut_a uses 4 ways x 2 sets,
//             dut_b uses 8 ways x 1 set. Expected victims are hand-derived.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_common_pseudo_lru_tree_binw;

   logic       clk = 1'b0;
   logic       reset;
   int         n_checks = 0;
   int         n_fail   = 0;

   // dut_a: SUBJECT_COUNT_LOG2=2, SET_COUNT_LOG2=1
   logic [0:0] a_wset, a_qset;
   logic [1:0] a_waddr, a_qaddr;
   logic [3:0] a_qinv;
   logic       a_wen, a_qen, a_qvalid, a_qfrominv;

   // dut_b: SUBJECT_COUNT_LOG2=3, SET_COUNT_LOG2=0
   logic [0:0] b_wset, b_qset;
   logic [2:0] b_waddr, b_qaddr;
   logic [7:0] b_qinv;
   logic       b_wen, b_qen, b_qvalid, b_qfrominv;

   always #5 clk = ~clk;

   common_pseudo_lru_tree_binw #(.SUBJECT_COUNT_LOG2(2), .SET_COUNT_LOG2(1)) dut_a (
      .clk(clk), .reset(reset),
      .wset(a_wset), .waddr(a_waddr), .wen(a_wen),
      .qset(a_qset), .qinvalid(a_qinv), .qen(a_qen),
      .qvalid(a_qvalid), .qaddr(a_qaddr), .qfrominv(a_qfrominv)
   );

   common_pseudo_lru_tree_binw #(.SUBJECT_COUNT_LOG2(3), .SET_COUNT_LOG2(0)) dut_b (
      .clk(clk), .reset(reset),
      .wset(b_wset), .waddr(b_waddr), .wen(b_wen),
      .qset(b_qset), .qinvalid(b_qinv), .qen(b_qen),
      .qvalid(b_qvalid), .qaddr(b_qaddr), .qfrominv(b_qfrominv)
   );

   // Advance past the next rising edge; outputs are sampled 1 time unit later.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      a_wen = 0; a_qen = 0; a_wset = 0; a_qset = 0; a_waddr = 0; a_qinv = 0;
      b_wen = 0; b_qen = 0; b_wset = 0; b_qset = 0; b_waddr = 0; b_qinv = 0;
   endtask

   task automatic do_reset;
      reset = 1; tick; reset = 0;
   endtask

   task automatic a_touch(input logic s, input logic [1:0] w);
      a_wen = 1; a_wset = s; a_waddr = w; tick; a_wen = 0;
   endtask

   task automatic a_query(input logic s, input logic [3:0] inv);
      a_qen = 1; a_qset = s; a_qinv = inv; tick; a_qen = 0; a_qinv = 0;
   endtask

   task automatic test_reset;
      idle;
      reset = 1; a_wen = 1; a_qen = 1; b_qen = 1; tick; tick;
      reset = 0; idle;
      n_checks++; if (a_qvalid !== 1'b0)   begin n_fail++; $display("FAIL reset_qvalid: got %0b expected 0", a_qvalid); end
      n_checks++; if (a_qaddr !== 2'd0)    begin n_fail++; $display("FAIL reset_qaddr: got %0d expected 0", a_qaddr); end
      n_checks++; if (a_qfrominv !== 1'b0) begin n_fail++; $display("FAIL reset_qfrominv: got %0b expected 0", a_qfrominv); end
      n_checks++; if (b_qvalid !== 1'b0)   begin n_fail++; $display("FAIL reset_b_qvalid: got %0b expected 0", b_qvalid); end
      a_query(0, 4'b0000);
      n_checks++; if (a_qvalid !== 1'b1)   begin n_fail++; $display("FAIL first_query_qvalid: got %0b expected 1", a_qvalid); end
      n_checks++; if (a_qaddr !== 2'd0)    begin n_fail++; $display("FAIL first_query_qaddr: got %0d expected 0", a_qaddr); end
      n_checks++; if (a_qfrominv !== 1'b0) begin n_fail++; $display("FAIL first_query_qfrominv: got %0b expected 0", a_qfrominv); end
   endtask

   task automatic test_touch_sets;
      do_reset;
      a_touch(0, 2'd0); a_touch(0, 2'd2); a_touch(0, 2'd1);
      a_query(0, 4'b0000);
      n_checks++; if (a_qaddr !== 2'd3) begin n_fail++; $display("FAIL touch_seq_set0: got %0d expected 3", a_qaddr); end
      a_query(1, 4'b0000);
      n_checks++; if (a_qaddr !== 2'd0) begin n_fail++; $display("FAIL set1_independent: got %0d expected 0", a_qaddr); end
   endtask

   task automatic test_invalid;
      // Tree of set 0 still points at way 3 from the previous test.
      a_query(0, 4'b1100);
      n_checks++; if (a_qaddr !== 2'd2)    begin n_fail++; $display("FAIL inv_qaddr: got %0d expected 2", a_qaddr); end
      n_checks++; if (a_qfrominv !== 1'b1) begin n_fail++; $display("FAIL inv_qfrominv: got %0b expected 1", a_qfrominv); end
      a_query(0, 4'b0000);
      n_checks++; if (a_qaddr !== 2'd3)    begin n_fail++; $display("FAIL after_inv_tree: got %0d expected 3", a_qaddr); end
      n_checks++; if (a_qfrominv !== 1'b0) begin n_fail++; $display("FAIL after_inv_qfrominv: got %0b expected 0", a_qfrominv); end
   endtask

   task automatic test_hold;
      a_query(0, 4'b0010);
      tick;
      n_checks++; if (a_qvalid !== 1'b0)   begin n_fail++; $display("FAIL hold_qvalid: got %0b expected 0", a_qvalid); end
      n_checks++; if (a_qaddr !== 2'd1)    begin n_fail++; $display("FAIL hold_qaddr: got %0d expected 1", a_qaddr); end
      n_checks++; if (a_qfrominv !== 1'b1) begin n_fail++; $display("FAIL hold_qfrominv: got %0b expected 1", a_qfrominv); end
   endtask

   task automatic test_read_before_write;
      do_reset;
      a_wen = 1; a_wset = 0; a_waddr = 2'd0;
      a_qen = 1; a_qset = 0; a_qinv = 4'b0000;
      tick; idle;
      n_checks++; if (a_qaddr !== 2'd0) begin n_fail++; $display("FAIL rbw_same_edge: got %0d expected 0", a_qaddr); end
      a_query(0, 4'b0000);
      n_checks++; if (a_qaddr !== 2'd2) begin n_fail++; $display("FAIL rbw_next: got %0d expected 2", a_qaddr); end
   endtask

   task automatic test_back_to_back;
      do_reset;
      a_qen = 1; a_qset = 0; a_wen = 1; a_wset = 0;
      a_waddr = 2'd0; tick;
      n_checks++; if (a_qaddr !== 2'd0 || a_qvalid !== 1'b1) begin n_fail++; $display("FAIL b2b_0: got %0d/%0b expected 0/1", a_qaddr, a_qvalid); end
      a_waddr = 2'd2; tick;
      n_checks++; if (a_qaddr !== 2'd2 || a_qvalid !== 1'b1) begin n_fail++; $display("FAIL b2b_1: got %0d/%0b expected 2/1", a_qaddr, a_qvalid); end
      a_waddr = 2'd1; tick;
      n_checks++; if (a_qaddr !== 2'd1 || a_qvalid !== 1'b1) begin n_fail++; $display("FAIL b2b_2: got %0d/%0b expected 1/1", a_qaddr, a_qvalid); end
      a_wen = 0; tick; idle;
      n_checks++; if (a_qaddr !== 2'd3 || a_qvalid !== 1'b1) begin n_fail++; $display("FAIL b2b_3: got %0d/%0b expected 3/1", a_qaddr, a_qvalid); end
   endtask

   task automatic test_idempotent;
      do_reset;
      a_touch(1, 2'd2); a_touch(1, 2'd2);
      a_query(1, 4'b0000);
      n_checks++; if (a_qaddr !== 2'd0) begin n_fail++; $display("FAIL idempotent: got %0d expected 0", a_qaddr); end
   endtask

   task automatic test_reset_priority;
      do_reset;
      // Touch way 0 while producing a non-zero result from the invalid mask.
      a_wen = 1; a_wset = 0; a_waddr = 2'd0;
      a_qen = 1; a_qset = 0; a_qinv = 4'b1000;
      tick;
      n_checks++; if (a_qaddr !== 2'd3 || a_qfrominv !== 1'b1) begin n_fail++; $display("FAIL pre_reset_result: got %0d/%0b expected 3/1", a_qaddr, a_qfrominv); end
      reset = 1; a_waddr = 2'd1; a_qinv = 4'b0000;
      tick; reset = 0; idle;
      n_checks++; if (a_qvalid !== 1'b0)   begin n_fail++; $display("FAIL rst_prio_qvalid: got %0b expected 0", a_qvalid); end
      n_checks++; if (a_qaddr !== 2'd0)    begin n_fail++; $display("FAIL rst_prio_qaddr: got %0d expected 0", a_qaddr); end
      n_checks++; if (a_qfrominv !== 1'b0) begin n_fail++; $display("FAIL rst_prio_qfrominv: got %0b expected 0", a_qfrominv); end
      a_query(0, 4'b0000);
      n_checks++; if (a_qaddr !== 2'd0) begin n_fail++; $display("FAIL post_reset_query: got %0d expected 0", a_qaddr); end
   endtask

   task automatic test_eight_way;
      do_reset;
      for (int w = 0; w < 8; w++) begin
         b_wen = 1; b_waddr = 3'(w); tick;
      end
      b_wen = 0;
      b_qen = 1; tick; b_qen = 0;
      n_checks++; if (b_qaddr !== 3'd0 || b_qvalid !== 1'b1) begin n_fail++; $display("FAIL b_all_touched: got %0d/%0b expected 0/1", b_qaddr, b_qvalid); end
      b_wen = 1; b_waddr = 3'd0; tick; b_wen = 0;
      b_qen = 1; tick; b_qen = 0;
      n_checks++; if (b_qaddr !== 3'd4) begin n_fail++; $display("FAIL b_touch0: got %0d expected 4", b_qaddr); end
      b_qen = 1; b_qinv = 8'b1010_0000; tick; b_qen = 0; b_qinv = 0;
      n_checks++; if (b_qaddr !== 3'd5 || b_qfrominv !== 1'b1) begin n_fail++; $display("FAIL b_invalid: got %0d/%0b expected 5/1", b_qaddr, b_qfrominv); end
   endtask

   initial begin
      reset = 1;
      idle;
      test_reset;
      test_touch_sets;
      test_invalid;
      test_hold;
      test_read_before_write;
      test_back_to_back;
      test_idempotent;
      test_reset_priority;
      test_eight_way;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
